mcpu_core_stage_mem_pipe: RTL and testbench

Parametrised, fully handshaked memory stage for the MCPU core, sitting between the address/PC stage and writeback. It replaces the combinational, tri-state-bus memory stage. Each instruction is registered, and the stage issues at most one data-cache request with separate read and write data buses. It adds sign-extending loads, alignment-fault detection, a flush that safely drains an in-flight cache access, and a registered writeback slot with valid/ready backpressure.

---
 rtl/mcpu_core_stage_mem_pipe.sv | 174 +++++++++++++++++
 tb/tb_mcpu_core_stage_mem_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_stage_mem_pipe.sv
// MCPU memory stage: registers each instruction, issues at most one data-cache
// request, and presents the result through a valid/ready writeback slot.
module mcpu_core_stage_mem_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic                                      clkrst_core_clk,
  input  logic                                      clkrst_core_rst_n,
  input  logic                                      pc2mem_valid,
  output logic                                      pc2mem_ready,
  input  logic [ADDR_W-1:0]                         pc2mem_in_paddr,
  input  logic [DATA_W-1:0]                         pc2mem_in_data,
  input  logic [3:0]                                pc2mem_in_type,
  input  logic                                      pc2mem_in_sext,
  input  logic [RD_W-1:0]                           pc2mem_in_rd_num,
  input  logic                                      pc2mem_in_rd_we,
  input  logic [DATA_W-1:0]                         pc2mem_in_result,
  input  logic                                      pc2mem_flush,
  output logic                                      mem2dc_valid,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]        mem2dc_paddr,
  output logic [DATA_W/8-1:0]                       mem2dc_write,
  output logic [DATA_W-1:0]                         mem2dc_wdata,
  input  logic                                      dc2mem_done,
  input  logic [DATA_W-1:0]                         dc2mem_rdata,
  output logic                                      mem2wb_valid,
  input  logic                                      mem2wb_ready,
  output logic [DATA_W-1:0]                         mem2wb_out_data,
  output logic [RD_W-1:0]                           mem2wb_out_rd_num,
  output logic                                      mem2wb_out_rd_we,
  output logic                                      mem2wb_out_fault
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

  state_t state, state_nxt;

  logic [OFF_W-1:0]  req_off;
  logic [1:0]        req_size;
  logic              req_sext;
  logic              req_store;
  logic [RD_W-1:0]   req_rd;
  logic              req_we;

  logic              accept, start, done_ok, dc_done, slot_load;
  logic [DATA_W-1:0] slot_data;
  logic [RD_W-1:0]   slot_rd;
  logic              slot_we, slot_fault;

  // Input decode: alignment check, byte-lane mask and lane-aligned store data
  logic [1:0]        in_size;
  logic [OFF_W-1:0]  in_off;
  logic [2:0]        align_mask;
  logic              in_fault;
  logic [15:0]       lane_bits;
  logic [LANES-1:0]  in_write;
  logic [DATA_W-1:0] in_wdata;

  assign in_size    = pc2mem_in_type[1:0];
  assign in_off     = pc2mem_in_paddr[OFF_W-1:0];
  assign align_mask = 3'((4'(1) << in_size) - 4'(1));
  assign in_fault   = (32'(in_size) > OFF_W) | (|(pc2mem_in_paddr[2:0] & align_mask));
  assign lane_bits  = (16'(1) << (5'(1) << in_size)) - 16'(1);
  assign in_write   = pc2mem_in_type[2] ? LANES'(lane_bits << in_off) : '0;
  assign in_wdata   = pc2mem_in_data << {in_off, 3'b000};

  // Load return: align to bit 0, mask to the access size, then extend
  logic [DATA_W-1:0] shifted, lmask, ld_data;
  logic [6:0]        nbits;
  logic [IDX_W-1:0]  sidx;
  logic              sign;

  assign shifted = dc2mem_rdata >> {req_off, 3'b000};
  assign nbits   = 7'(8) << req_size;
  assign lmask   = ~({DATA_W{1'b1}} << nbits);
  assign sidx    = IDX_W'(nbits - 7'(1));
  assign sign    = req_sext & shifted[sidx];
  assign ld_data = (shifted & lmask) | (sign ? ~lmask : '0);

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) state <= IDLE;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (dc2mem_done) state_nxt = IDLE;
               else if (pc2mem_flush) state_nxt = DRAIN;
      DRAIN:   if (dc2mem_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc2mem_ready = (state == IDLE) & (~mem2wb_valid | mem2wb_ready);
    accept       = pc2mem_valid & pc2mem_ready & ~pc2mem_flush;
    start        = accept & pc2mem_in_type[3] & ~in_fault;
    dc_done      = (state != IDLE) & dc2mem_done;
    done_ok      = (state == ACCESS) & dc2mem_done & ~pc2mem_flush;
    slot_load    = (accept & ~start) | done_ok;
    slot_data    = '0;
    slot_rd      = '0;
    slot_we      = 1'b0;
    slot_fault   = 1'b0;
    if (done_ok) begin
      slot_data = req_store ? '0 : ld_data;
      slot_rd   = req_rd;
      slot_we   = req_we;
    end else if (accept) begin
      slot_rd = pc2mem_in_rd_num;
      if (!pc2mem_in_type[3]) begin
        slot_data = pc2mem_in_result;
        slot_we   = pc2mem_in_rd_we;
      end else begin
        slot_fault = 1'b1;
      end
    end
  end

  // Cache request register; fields stay stable until the access completes
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      mem2dc_valid <= 1'b0;
      mem2dc_paddr <= '0;
      mem2dc_write <= '0;
      mem2dc_wdata <= '0;
      req_off      <= '0;
      req_size     <= '0;
      req_sext     <= 1'b0;
      req_store    <= 1'b0;
      req_rd       <= '0;
      req_we       <= 1'b0;
    end else if (start) begin
      mem2dc_valid <= 1'b1;
      mem2dc_paddr <= pc2mem_in_paddr[ADDR_W-1:OFF_W];
      mem2dc_write <= in_write;
      mem2dc_wdata <= in_wdata;
      req_off      <= in_off;
      req_size     <= in_size;
      req_sext     <= pc2mem_in_sext;
      req_store    <= pc2mem_in_type[2];
      req_rd       <= pc2mem_in_rd_num;
      req_we       <= pc2mem_in_rd_we;
    end else if (dc_done) begin
      mem2dc_valid <= 1'b0;
    end
  end

  // Writeback slot; a reload in the same cycle as a drain keeps it valid
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      mem2wb_valid      <= 1'b0;
      mem2wb_out_data   <= '0;
      mem2wb_out_rd_num <= '0;
      mem2wb_out_rd_we  <= 1'b0;
      mem2wb_out_fault  <= 1'b0;
    end else if (slot_load) begin
      mem2wb_valid      <= 1'b1;
      mem2wb_out_data   <= slot_data;
      mem2wb_out_rd_num <= slot_rd;
      mem2wb_out_rd_we  <= slot_we;
      mem2wb_out_fault  <= slot_fault;
    end else if (pc2mem_flush | mem2wb_ready) begin
      mem2wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcpu_core_stage_mem_pipe.sv
// Directed bench for mcpu_core_stage_mem_pipe: a 32-bit instance for most
// scenarios and a 64-bit instance for wide-lane stores.
module tb_mcpu_core_stage_mem_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        valid, ready, sext, we, flush, dc_valid, done, wb_valid, wb_ready;
  logic [31:0] paddr, data, result, dc_wdata, rdata, wb_data;
  logic [3:0]  typ, dc_write;
  logic [4:0]  rd, wb_rd;
  logic [29:0] dc_paddr;
  logic        wb_we, wb_fault;

  logic        valid64, ready64, dc_valid64, done64, wb_valid64, wb_we64, wb_fault64;
  logic [31:0] paddr64;
  logic [63:0] data64, dc_wdata64, wb_data64;
  logic [3:0]  typ64;
  logic [7:0]  dc_write64;
  logic [28:0] dc_paddr64;
  logic [4:0]  wb_rd64;

  mcpu_core_stage_mem_pipe #(.DATA_W(32), .ADDR_W(32), .RD_W(5)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .pc2mem_valid(valid), .pc2mem_ready(ready), .pc2mem_in_paddr(paddr),
    .pc2mem_in_data(data), .pc2mem_in_type(typ), .pc2mem_in_sext(sext),
    .pc2mem_in_rd_num(rd), .pc2mem_in_rd_we(we), .pc2mem_in_result(result),
    .pc2mem_flush(flush), .mem2dc_valid(dc_valid), .mem2dc_paddr(dc_paddr),
    .mem2dc_write(dc_write), .mem2dc_wdata(dc_wdata), .dc2mem_done(done),
    .dc2mem_rdata(rdata), .mem2wb_valid(wb_valid), .mem2wb_ready(wb_ready),
    .mem2wb_out_data(wb_data), .mem2wb_out_rd_num(wb_rd),
    .mem2wb_out_rd_we(wb_we), .mem2wb_out_fault(wb_fault)
  );

  mcpu_core_stage_mem_pipe #(.DATA_W(64), .ADDR_W(32), .RD_W(5)) dut64 (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .pc2mem_valid(valid64), .pc2mem_ready(ready64), .pc2mem_in_paddr(paddr64),
    .pc2mem_in_data(data64), .pc2mem_in_type(typ64), .pc2mem_in_sext(1'b0),
    .pc2mem_in_rd_num(5'd0), .pc2mem_in_rd_we(1'b0), .pc2mem_in_result(64'd0),
    .pc2mem_flush(1'b0), .mem2dc_valid(dc_valid64), .mem2dc_paddr(dc_paddr64),
    .mem2dc_write(dc_write64), .mem2dc_wdata(dc_wdata64), .dc2mem_done(done64),
    .dc2mem_rdata(64'd0), .mem2wb_valid(wb_valid64), .mem2wb_ready(1'b1),
    .mem2wb_out_data(wb_data64), .mem2wb_out_rd_num(wb_rd64),
    .mem2wb_out_rd_we(wb_we64), .mem2wb_out_fault(wb_fault64)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 0; sext = 0; we = 0; flush = 0; done = 0; wb_ready = 1;
    paddr = 0; data = 0; result = 0; rdata = 0; typ = 0; rd = 0;
    valid64 = 0; done64 = 0; paddr64 = 0; data64 = 0; typ64 = 0;
    repeat (3) step();
    rst_n = 1'b1;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
    vectors++; if (dc_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dc_valid got %0b want 0", dc_valid); end
    vectors++; if ({dc_paddr, dc_write, dc_wdata} !== '0) begin miscompares++; $display("FAIL reset_dc_fields got %h/%h/%h want 0", dc_paddr, dc_write, dc_wdata); end
    vectors++; if ({wb_data, wb_rd, wb_we, wb_fault} !== '0) begin miscompares++; $display("FAIL reset_wb_fields got %h/%h/%b/%b want 0", wb_data, wb_rd, wb_we, wb_fault); end
    step();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", ready); end
  endtask

  task automatic test_nonmem();
    valid = 1; typ = 4'b0000; result = 32'h1234_5678; rd = 5'd3; we = 1;
    step();
    valid = 0;
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL nonmem_valid got %0b want 1", wb_valid); end
    vectors++; if (wb_data !== 32'h1234_5678) begin miscompares++; $display("FAIL nonmem_data got %h want 12345678", wb_data); end
    vectors++; if ({wb_rd, wb_we, wb_fault} !== {5'd3, 1'b1, 1'b0}) begin miscompares++; $display("FAIL nonmem_ctl got rd=%0d we=%b f=%b want 3/1/0", wb_rd, wb_we, wb_fault); end
    vectors++; if (dc_valid !== 1'b0) begin miscompares++; $display("FAIL nonmem_no_dc got %0b want 0", dc_valid); end
    step();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL nonmem_drain got %0b want 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    valid = 1; typ = 4'b0000; result = 32'h11; rd = 5'd1; we = 1;
    step();
    result = 32'h22; rd = 5'd2;
    vectors++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h11, 5'd1}) begin miscompares++; $display("FAIL b2b_first got v=%b d=%h rd=%0d want 1/11/1", wb_valid, wb_data, wb_rd); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %0b want 1", ready); end
    step();
    valid = 0;
    vectors++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h22, 5'd2}) begin miscompares++; $display("FAIL b2b_second got v=%b d=%h rd=%0d want 1/22/2", wb_valid, wb_data, wb_rd); end
    step();
  endtask

  task automatic test_load_sb();
    valid = 1; typ = 4'b1000; paddr = 32'h103; sext = 1; rd = 5'd7; we = 1;
    step();
    valid = 0; sext = 0;
    vectors++; if ({dc_valid, dc_paddr, dc_write} !== {1'b1, 30'h40, 4'h0}) begin miscompares++; $display("FAIL lb_req got v=%b a=%h w=%h want 1/40/0", dc_valid, dc_paddr, dc_write); end
    vectors++; if ({ready, wb_valid} !== 2'b00) begin miscompares++; $display("FAIL lb_busy got rdy=%b wbv=%b want 0/0", ready, wb_valid); end
    step();
    vectors++; if (dc_valid !== 1'b1) begin miscompares++; $display("FAIL lb_hold got %0b want 1", dc_valid); end
    step();
    done = 1; rdata = 32'h80FF_FF00;
    step();
    done = 0;
    vectors++; if ({wb_valid, wb_data} !== {1'b1, 32'hFFFF_FF80}) begin miscompares++; $display("FAIL lb_data got v=%b d=%h want 1/ffffff80", wb_valid, wb_data); end
    vectors++; if ({wb_rd, wb_we, wb_fault, dc_valid, ready} !== {5'd7, 4'b1001}) begin miscompares++; $display("FAIL lb_ctl got rd=%0d we=%b f=%b dcv=%b rdy=%b want 7/1/0/0/1", wb_rd, wb_we, wb_fault, dc_valid, ready); end
    step();
    // Zero-extended half load, done at k=1
    valid = 1; typ = 4'b1001; paddr = 32'h102; sext = 0; rd = 5'd8;
    step();
    valid = 0; done = 1; rdata = 32'h80FF_1234;
    vectors++; if (dc_paddr !== 30'h40) begin miscompares++; $display("FAIL lhu_addr got %h want 40", dc_paddr); end
    step();
    done = 0;
    vectors++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_80FF}) begin miscompares++; $display("FAIL lhu_data got v=%b d=%h want 1/000080ff", wb_valid, wb_data); end
    step();
  endtask

  task automatic test_store();
    valid64 = 1; typ64 = 4'b1101; paddr64 = 32'h0A; data64 = 64'hBEEF;
    valid = 1; typ = 4'b1100; paddr = 32'h101; data = 32'hA5; rd = 5'd0; we = 0;
    step();
    valid64 = 0; valid = 0;
    vectors++; if ({dc_valid64, dc_write64, dc_paddr64} !== {1'b1, 8'h0C, 29'h1}) begin miscompares++; $display("FAIL sh64_req got v=%b w=%h a=%h want 1/0c/1", dc_valid64, dc_write64, dc_paddr64); end
    vectors++; if (dc_wdata64 !== 64'h0000_0000_BEEF_0000) begin miscompares++; $display("FAIL sh64_wdata got %h want 00000000beef0000", dc_wdata64); end
    vectors++; if ({dc_write, dc_wdata} !== {4'b0010, 32'h0000_A500}) begin miscompares++; $display("FAIL sb32_req got w=%b d=%h want 0010/0000a500", dc_write, dc_wdata); end
    done64 = 1; done = 1; rdata = 32'hFFFF_FFFF;
    step();
    done64 = 0; done = 0;
    vectors++; if ({wb_valid64, wb_data64, wb_fault64} !== {1'b1, 64'd0, 1'b0}) begin miscompares++; $display("FAIL sh64_wb got v=%b d=%h f=%b want 1/0/0", wb_valid64, wb_data64, wb_fault64); end
    vectors++; if ({wb_valid, wb_data} !== {1'b1, 32'd0}) begin miscompares++; $display("FAIL sb32_wb got v=%b d=%h want 1/0", wb_valid, wb_data); end
    step();
  endtask

  task automatic test_misaligned();
    valid = 1; typ = 4'b1010; paddr = 32'h2; rd = 5'd9; we = 1;
    step();
    typ = 4'b1011; paddr = 32'h10;
    vectors++; if ({dc_valid, wb_valid, wb_fault, wb_we, wb_data} !== {4'b0110, 32'd0}) begin miscompares++; $display("FAIL mis_word got dcv=%b v=%b f=%b we=%b d=%h want 0/1/1/0/0", dc_valid, wb_valid, wb_fault, wb_we, wb_data); end
    step();
    valid = 0;
    vectors++; if ({dc_valid, wb_valid, wb_fault} !== 3'b011) begin miscompares++; $display("FAIL mis_dword got dcv=%b v=%b f=%b want 0/1/1", dc_valid, wb_valid, wb_fault); end
    step();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL mis_drain got %0b want 0", wb_valid); end
  endtask

  task automatic test_flush_access();
    valid = 1; typ = 4'b1010; paddr = 32'h200; rd = 5'd5; we = 1;
    step();
    valid = 0; flush = 1;
    vectors++; if (dc_valid !== 1'b1) begin miscompares++; $display("FAIL fl_start got %0b want 1", dc_valid); end
    step();
    flush = 0;
    for (int c = 2; c < 6; c++) begin
      vectors++; if ({dc_valid, ready, wb_valid} !== 3'b100) begin miscompares++; $display("FAIL fl_drain_c%0d got dcv=%b rdy=%b wbv=%b want 1/0/0", c, dc_valid, ready, wb_valid); end
      step();
    end
    done = 1; rdata = 32'hDEAD_BEEF;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL fl_done_ready got %0b want 0", ready); end
    step();
    done = 0;
    vectors++; if ({dc_valid, wb_valid, ready} !== 3'b001) begin miscompares++; $display("FAIL fl_after got dcv=%b wbv=%b rdy=%b want 0/0/1", dc_valid, wb_valid, ready); end
    // Flush coinciding with done discards the result
    valid = 1; paddr = 32'h204;
    step();
    valid = 0; flush = 1; done = 1;
    step();
    flush = 0; done = 0;
    vectors++; if ({dc_valid, wb_valid, ready} !== 3'b001) begin miscompares++; $display("FAIL fl_same got dcv=%b wbv=%b rdy=%b want 0/0/1", dc_valid, wb_valid, ready); end
  endtask

  task automatic test_backpressure();
    wb_ready = 0;
    valid = 1; typ = 4'b1010; paddr = 32'h300; sext = 0; rd = 5'd6; we = 1;
    step();
    valid = 0; done = 1; rdata = 32'hCAFE_F00D;
    step();
    done = 0;
    vectors++; if ({wb_valid, wb_data, wb_rd, ready} !== {1'b1, 32'hCAFE_F00D, 5'd6, 1'b0}) begin miscompares++; $display("FAIL bp_load got v=%b d=%h rd=%0d rdy=%b want 1/cafef00d/6/0", wb_valid, wb_data, wb_rd, ready); end
    step();
    vectors++; if ({wb_valid, wb_data, ready} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin miscompares++; $display("FAIL bp_hold got v=%b d=%h rdy=%b want 1/cafef00d/0", wb_valid, wb_data, ready); end
    wb_ready = 1; valid = 1; typ = 4'b0000; result = 32'h55; rd = 5'd4;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %0b want 1", ready); end
    step();
    valid = 0;
    vectors++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h55, 5'd4}) begin miscompares++; $display("FAIL bp_reload got v=%b d=%h rd=%0d want 1/55/4", wb_valid, wb_data, wb_rd); end
    step();
  endtask

  task automatic test_flush_idle();
    wb_ready = 0; valid = 1; typ = 4'b0000; result = 32'h77; rd = 5'd2;
    step();
    wb_ready = 1; flush = 1; result = 32'h99;
    step();
    flush = 0; valid = 0;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flidle_valid got %0b want 0", wb_valid); end
    done = 1;
    step();
    done = 0;
    vectors++; if ({wb_valid, dc_valid} !== 2'b00) begin miscompares++; $display("FAIL done_idle got wbv=%b dcv=%b want 0/0", wb_valid, dc_valid); end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_back_to_back();
    test_load_sb();
    test_store();
    test_misaligned();
    test_flush_access();
    test_backpressure();
    test_flush_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
